// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: EX-stage MULT sequencer driving a sequential Booth core and owning HI/LO
module mult_hilo_ctrl #(
    parameter int TIMEOUT = 32,
    parameter int CW      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mult_valid,
    input  logic [15:0] ex_rs,
    input  logic [15:0] ex_rt,
    input  logic        ex_mfhi,
    input  logic        ex_mflo,
    input  logic        ex_flush,
    output logic        core_start,
    output logic [15:0] core_a,
    output logic [15:0] core_b,
    input  logic        core_ready,
    input  logic [31:0] core_result,
    output logic [15:0] hi,
    output logic [15:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, CLEAR} state_t;
    state_t state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    // State and datapath registers; reset returns everything to zero/IDLE at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    // Next state: ARM holds start low so the core re-initialises; flush aborts before capture only
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (ex_mult_valid && !ex_flush) begin
                a_d     = ex_rs;
                b_d     = ex_rt;
                state_d = ARM;
            end
            ARM: begin
                cnt_d   = '0;
                state_d = ex_flush ? IDLE : RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (ex_flush) state_d = IDLE;
                else if (core_ready) begin
                    hi_d    = core_result[31:16];
                    lo_d    = core_result[15:0];
                    state_d = CLEAR;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = IDLE;
        endcase
    end
    assign core_start = (state_q == RUN);
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign stall      = busy && (ex_mfhi || ex_mflo || ex_mult_valid);
endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- EX-stage sequencer for MULT instructions in the pipelined MIPS.
- Accepts a MULT from EX, captures the two 16-bit signed operands and drives the sequential Booth multiplier core through its start/ready handshake.
- Writes the 32-bit product into the HI/LO registers.
- Stalls the pipeline only when a later instruction needs HI/LO, or issues another MULT, while a multiply is still in flight.

Parameters:
- TIMEOUT, 32, maximum RUN cycles to wait for core_ready before aborting (must be > core latency, 17).
- CW, 6, width of the RUN-cycle counter (2^CW > TIMEOUT).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_mult_valid  in  1  EX holds a valid MULT.
- ex_rs  in  16  signed multiplicand (rs value).
- ex_rt  in  16  signed multiplier (rt value).
- ex_mfhi  in  1  EX holds MFHI.
- ex_mflo  in  1  EX holds MFLO.
- ex_flush  in  1  pipeline flush; aborts any in-flight multiply.
- core_start  out  1  level start to multiplier core. Low forces the core back to its initial state; high runs it.
- core_a  out  16  operand A to core.
- core_b  out  16  operand B to core.
- core_ready  in  1  core finished; product valid on core_result.
- core_result  in  32  signed product from core.
- hi  out  16  HI register (product[31:16]).
- lo  out  16  LO register (product[15:0]).
- busy  out  1  multiply in flight (state != IDLE).
- stall  out  1  hold IF/ID/EX this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state = IDLE; core_start, busy, stall, err = 0; hi, lo, core_a, core_b = 0; counter = 0.
- States: IDLE, ARM, RUN, CLEAR.
- IDLE:
  - core_start = 0.
  - If ex_mult_valid & ~ex_flush: latch core_a <= ex_rs and core_b <= ex_rt, then go to ARM.
  - The MULT itself is not stalled; it retires down the pipeline.
- ARM (exactly 1 cycle):
  - core_start = 0 with operands already stable, guaranteeing the core re-initialises.
  - Counter <= 0, then go to RUN.
- RUN:
  - core_start = 1; counter increments each cycle.
  - On core_ready = 1: hi <= core_result[31:16], lo <= core_result[15:0], go to CLEAR.
  - If counter reaches TIMEOUT with no ready: err <= 1, hi/lo unchanged, go to CLEAR.
- CLEAR (exactly 1 cycle): core_start = 0, then go to IDLE.
- Operands core_a/core_b hold constant from ARM through CLEAR.
- busy = (state != IDLE). stall = busy & (ex_mfhi | ex_mflo | ex_mult_valid), combinational.
- A stalled MFHI/MFLO/MULT is held in EX and proceeds in the first IDLE cycle.
  - MFHI/MFLO therefore read hi/lo already updated by the capture edge.
- A stalled MULT is accepted in that IDLE cycle.
- Multiply latency: ARM 1 + RUN (core latency + 1) + CLEAR 1 cycles. With the 17-step core, busy is high for about 20 cycles.
- ex_flush:
  - In ARM or RUN: core_start drops to 0 next cycle, state goes to IDLE, hi/lo unchanged, no err.
  - In CLEAR: the capture has already completed and is kept.
  - In IDLE: blocks acceptance that cycle.
- Simultaneous ex_mult_valid and ex_mfhi/ex_mflo cannot occur (single EX slot); if both are asserted, MULT has priority.
- core_ready sampled in any state other than RUN is ignored.
- err clears only on reset.

Test Plan:
- ex_rs=3, ex_rt=-5 (0xFFFB), one-cycle ex_mult_valid → core_start low 1 cycle then high; after ready, hi=0xFFFF, lo=0xFFF1; busy falls 1 cycle after capture.
- ex_rs=0x8000, ex_rt=0x8000 → hi=0x4000, lo=0x0000. Also 0x7FFF × 0x8000 → hi=0xC000, lo=0x8000.
- MULT 7×6, then ex_mflo held 2 cycles later → stall high until first IDLE cycle; MFLO then reads lo=0x002A with stall low.
- Back-to-back MULT (2×2, then 4×4 presented while busy) → second stalled; core_start pulses low ≥1 cycle between runs; final lo=0x0010.
- Core model with ready never asserted → after TIMEOUT RUN cycles err=1, hi/lo keep prior values, state returns to IDLE.
- ex_flush, and separately rst_n low, asserted mid-RUN → core_start=0 next cycle (immediately for reset), hi/lo unchanged by flush and zeroed by reset, busy=0.
